// File: rtl/hazard_pkg.sv
// Shared types and helpers for the N-issue hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StMduWait
  } haz_state_e;

  localparam int unsigned FWD_REGFILE = 0;

  // Encoding: 0 = register file, 1+k = M lane k, 1+lanes+k = W lane k.
  function automatic int unsigned fwd_sel(int unsigned lane, logic is_w, int unsigned lanes);
    return is_w ? (1 + lanes + lane) : (1 + lane);
  endfunction

endpackage

// File: rtl/hazard_ctrl_nway_if.sv
// Pipeline-side bundle of the hazard controller. Optional perf counters: HAZ_PERF_CNT_EN.
interface hazard_ctrl_nway_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned REGW  = 5
);
  localparam int unsigned FWD_W = $clog2(2 * LANES + 1);

  logic [LANES*REGW-1:0]  rs1_d;
  logic [LANES*REGW-1:0]  rs2_d;
  logic [LANES*REGW-1:0]  rs1_e;
  logic [LANES*REGW-1:0]  rs2_e;
  logic [LANES*REGW-1:0]  rd_e;
  logic [LANES-1:0]       memread_e;
  logic [LANES*REGW-1:0]  rd_m;
  logic [LANES*REGW-1:0]  rd_w;
  logic [LANES-1:0]       regwrite_m;
  logic [LANES-1:0]       regwrite_w;
  logic                   redirect_e;
  logic                   mdu_start_e;
  logic                   mdu_done;

  logic [LANES*FWD_W-1:0] fwd1_e;
  logic [LANES*FWD_W-1:0] fwd2_e;
  logic [LANES-1:0]       we_w_mask;
  logic                   stall_f;
  logic                   stall_d;
  logic                   stall_e;
  logic                   flush_d;
  logic                   flush_e;
  logic                   mdu_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]            lu_stall_cnt;
  logic [31:0]            mdu_stall_cnt;
  logic [31:0]            flush_cnt;
`endif

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, memread_e, rd_m, rd_w,
    output regwrite_m, regwrite_w, redirect_e, mdu_start_e, mdu_done,
    input  fwd1_e, fwd2_e, we_w_mask, stall_f, stall_d, stall_e, flush_d, flush_e,
    input  mdu_timeout
`ifdef HAZ_PERF_CNT_EN
    , input lu_stall_cnt, mdu_stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, memread_e, rd_m, rd_w,
    input  regwrite_m, regwrite_w, redirect_e, mdu_start_e, mdu_done,
    output fwd1_e, fwd2_e, we_w_mask, stall_f, stall_d, stall_e, flush_d, flush_e,
    output mdu_timeout
`ifdef HAZ_PERF_CNT_EN
    , output lu_stall_cnt, mdu_stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_fwd_lane.sv
// Priority forward selector for one source operand of one issue lane.
module hazard_fwd_lane
  import hazard_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned REGW  = 5,
  parameter int unsigned FWD_W = $clog2(2 * LANES + 1)
) (
  input  logic [REGW-1:0]       src,
  input  logic [LANES*REGW-1:0] rd_m,
  input  logic [LANES*REGW-1:0] rd_w,
  input  logic [LANES-1:0]      regwrite_m,
  input  logic [LANES-1:0]      regwrite_w,
  output logic [FWD_W-1:0]      sel
);

  // Later assignments override earlier ones: W lanes, then M lanes, youngest last.
  always_comb begin
    sel = FWD_W'(FWD_REGFILE);
    if (src != '0) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (regwrite_w[k] && (rd_w[k*REGW +: REGW] == src)) begin
          sel = FWD_W'(fwd_sel(k, 1'b1, LANES));
        end
      end
      for (int unsigned k = 0; k < LANES; k++) begin
        if (regwrite_m[k] && (rd_m[k*REGW +: REGW] == src)) begin
          sel = FWD_W'(fwd_sel(k, 1'b0, LANES));
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_nway.sv
// N-issue hazard controller: forwarding, W write masking, load-use and MDU/flush FSM.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl_nway
  import hazard_pkg::*;
#(
  parameter int unsigned LANES        = 2,
  parameter int unsigned REGW         = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MDU_TIMEOUT  = 64,
  parameter int unsigned FWD_W        = $clog2(2 * LANES + 1)
) (
  input logic               clk,
  input logic               rst_n,
  hazard_ctrl_nway_if.slave hz
);

  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > MDU_TIMEOUT) ? FLUSH_CYCLES : MDU_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CntFlushLoad = cnt_t'(FLUSH_CYCLES - 1);
  localparam cnt_t CntMduLast   = cnt_t'(MDU_TIMEOUT - 1);

  haz_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       cnt_inc, cnt_dec;

  logic [LANES*FWD_W-1:0] fwd1, fwd2;
  logic [LANES-1:0]       we_mask;
  logic                   lu;
  logic                   stall_fd_c, stall_e_c, flush_d_c, flush_e_c, tmo_c;

  // Forwarding

  for (genvar g = 0; g < LANES; g++) begin : g_fwd
    hazard_fwd_lane #(
      .LANES (LANES),
      .REGW  (REGW),
      .FWD_W (FWD_W)
    ) u_fwd1 (
      .src        (hz.rs1_e[g*REGW +: REGW]),
      .rd_m       (hz.rd_m),
      .rd_w       (hz.rd_w),
      .regwrite_m (hz.regwrite_m),
      .regwrite_w (hz.regwrite_w),
      .sel        (fwd1[g*FWD_W +: FWD_W])
    );

    hazard_fwd_lane #(
      .LANES (LANES),
      .REGW  (REGW),
      .FWD_W (FWD_W)
    ) u_fwd2 (
      .src        (hz.rs2_e[g*REGW +: REGW]),
      .rd_m       (hz.rd_m),
      .rd_w       (hz.rd_w),
      .regwrite_m (hz.regwrite_m),
      .regwrite_w (hz.regwrite_w),
      .sel        (fwd2[g*FWD_W +: FWD_W])
    );
  end

  // Write-back masking: a younger lane writing the same rd suppresses older ones.

  always_comb begin
    we_mask = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      we_mask[k] = hz.regwrite_w[k] && (hz.rd_w[k*REGW +: REGW] != '0);
      for (int unsigned j = k + 1; j < LANES; j++) begin
        if (hz.regwrite_w[j] && (hz.rd_w[j*REGW +: REGW] == hz.rd_w[k*REGW +: REGW])) begin
          we_mask[k] = 1'b0;
        end
      end
    end
  end

  // Load-use detection

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (hz.memread_e[i] && (hz.rd_e[i*REGW +: REGW] != '0)) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          if ((hz.rd_e[i*REGW +: REGW] == hz.rs1_d[j*REGW +: REGW]) ||
              (hz.rd_e[i*REGW +: REGW] == hz.rs2_d[j*REGW +: REGW])) begin
            lu = 1'b1;
          end
        end
      end
    end
  end

  // Control FSM

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
  assign cnt_dec = (cnt_q == '0) ? cnt_q : cnt_q - cnt_t'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_fd_c = 1'b0;
    stall_e_c  = 1'b0;
    flush_d_c  = 1'b0;
    flush_e_c  = 1'b0;
    tmo_c      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (hz.redirect_e) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            cnt_d   = CntFlushLoad;
          end
        end else if (hz.mdu_start_e) begin
          stall_fd_c = 1'b1;
          stall_e_c  = 1'b1;
          state_d    = StMduWait;
          cnt_d      = '0;
        end else if (lu) begin
          stall_fd_c = 1'b1;
          flush_e_c  = 1'b1;
        end
      end

      StFlush: begin
        flush_d_c = 1'b1;
        flush_e_c = 1'b1;
        if (hz.redirect_e) begin
          cnt_d = CntFlushLoad;
        end else if (cnt_q <= cnt_t'(1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      StMduWait: begin
        // The accept cycle counts as wait cycle 0, so the timeout lands on accept+MDU_TIMEOUT-1.
        if (hz.mdu_done) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (cnt_inc >= CntMduLast) begin
          tmo_c   = 1'b1;
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          stall_fd_c = 1'b1;
          stall_e_c  = 1'b1;
          cnt_d      = cnt_inc;
        end
      end

      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall/flush are forced low while reset is held, independent of the inputs.
  assign hz.fwd1_e      = fwd1;
  assign hz.fwd2_e      = fwd2;
  assign hz.we_w_mask   = we_mask;
  assign hz.stall_f     = rst_n & stall_fd_c;
  assign hz.stall_d     = rst_n & stall_fd_c;
  assign hz.stall_e     = rst_n & stall_e_c;
  assign hz.flush_d     = rst_n & flush_d_c;
  assign hz.flush_e     = rst_n & flush_e_c;
  assign hz.mdu_timeout = rst_n & tmo_c;

`ifdef HAZ_PERF_CNT_EN
  // Event classes are disjoint: load-use never stalls E, MDU always does, redirect flushes D.
  logic        lu_ev, mdu_ev, flush_ev;
  logic [31:0] lu_cnt_q, mdu_cnt_q, flush_cnt_q;

  assign lu_ev    = stall_fd_c & ~stall_e_c;
  assign mdu_ev   = stall_e_c;
  assign flush_ev = flush_d_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q    <= '0;
      mdu_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_ev && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (mdu_ev && (mdu_cnt_q != '1)) mdu_cnt_q <= mdu_cnt_q + 32'd1;
      if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.lu_stall_cnt  = lu_cnt_q;
  assign hz.mdu_stall_cnt = mdu_cnt_q;
  assign hz.flush_cnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_nway.sv
// Randomised plus directed bench for hazard_ctrl_nway against a behavioural model.
module tb_hazard_ctrl_nway;

  localparam int L  = 2;
  localparam int RW = 5;
  localparam int FC = 3;
  localparam int MT = 8;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_nway_if #(.LANES(L), .REGW(RW)) hz ();

  hazard_ctrl_nway #(
    .LANES        (L),
    .REGW         (RW),
    .FLUSH_CYCLES (FC),
    .MDU_TIMEOUT  (MT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: first matching producer in priority order (M youngest..oldest, then W).
  function automatic int exp_fwd(input logic [RW-1:0] src);
    if (src == '0) return 0;
    for (int k = L - 1; k >= 0; k--)
      if (hz.regwrite_m[k] && hz.rd_m[k*RW +: RW] == src) return 1 + k;
    for (int k = L - 1; k >= 0; k--)
      if (hz.regwrite_w[k] && hz.rd_w[k*RW +: RW] == src) return 1 + L + k;
    return 0;
  endfunction

  function automatic logic [L-1:0] exp_we();
    logic [L-1:0] m;
    m = '0;
    for (int k = 0; k < L; k++) begin
      bit beaten;
      beaten = 1'b0;
      for (int j = 0; j < L; j++)
        if (j > k && hz.regwrite_w[j] && hz.rd_w[j*RW +: RW] == hz.rd_w[k*RW +: RW]) beaten = 1'b1;
      m[k] = hz.regwrite_w[k] && hz.rd_w[k*RW +: RW] != 0 && !beaten;
    end
    return m;
  endfunction

  function automatic bit exp_lu();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++)
        if (hz.memread_e[i] && hz.rd_e[i*RW +: RW] != 0 &&
            (hz.rd_e[i*RW +: RW] == hz.rs1_d[j*RW +: RW] ||
             hz.rd_e[i*RW +: RW] == hz.rs2_d[j*RW +: RW])) return 1'b1;
    return 1'b0;
  endfunction

  // Sequencing model: remaining flush cycles, MDU busy flag and cycles since accept.
  int flush_rem = 0;
  bit mdu_busy  = 1'b0;
  int mdu_age   = 0;
  int lu_n = 0, mdu_n = 0, fl_n = 0;
  bit e_sf, e_se, e_fd, e_fe, e_to;

  always @(negedge clk) begin
    for (int i = 0; i < L; i++) begin
      chk("fwd1_e", 32'(hz.fwd1_e[i*FW +: FW]), 32'(exp_fwd(hz.rs1_e[i*RW +: RW])));
      chk("fwd2_e", 32'(hz.fwd2_e[i*FW +: FW]), 32'(exp_fwd(hz.rs2_e[i*RW +: RW])));
    end
    chk("we_w_mask", 32'(hz.we_w_mask), 32'(exp_we()));
    {e_sf, e_se, e_fd, e_fe, e_to} = '0;
    if (!rst_n) begin
      flush_rem = 0; mdu_busy = 1'b0; mdu_age = 0;
      lu_n = 0; mdu_n = 0; fl_n = 0;
    end else if (mdu_busy) begin
      if (hz.mdu_done) mdu_busy = 1'b0;
      else if (mdu_age == MT - 1) begin e_to = 1'b1; mdu_busy = 1'b0; end
      else begin e_sf = 1'b1; e_se = 1'b1; mdu_age++; mdu_n++; end
    end else if (hz.redirect_e || flush_rem > 0) begin
      e_fd = 1'b1; e_fe = 1'b1; fl_n++;
      flush_rem = hz.redirect_e ? FC - 1 : flush_rem - 1;
    end else if (hz.mdu_start_e) begin
      e_sf = 1'b1; e_se = 1'b1; mdu_busy = 1'b1; mdu_age = 1; mdu_n++;
    end else if (exp_lu()) begin
      e_sf = 1'b1; e_fe = 1'b1; lu_n++;
    end
    chk("stall_f", 32'(hz.stall_f), 32'(e_sf));
    chk("stall_d", 32'(hz.stall_d), 32'(e_sf));
    chk("stall_e", 32'(hz.stall_e), 32'(e_se));
    chk("flush_d", 32'(hz.flush_d), 32'(e_fd));
    chk("flush_e", 32'(hz.flush_e), 32'(e_fe));
    chk("mdu_timeout", 32'(hz.mdu_timeout), 32'(e_to));
  end

  task automatic idle();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0;
    hz.rd_m = '0; hz.rd_w = '0; hz.memread_e = '0; hz.regwrite_m = '0; hz.regwrite_w = '0;
    hz.redirect_e = 1'b0; hz.mdu_start_e = 1'b0; hz.mdu_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    for (int k = 0; k < L; k++) begin
      hz.rs1_d[k*RW +: RW] = RW'($urandom_range(0, 7));
      hz.rs2_d[k*RW +: RW] = RW'($urandom_range(0, 7));
      hz.rs1_e[k*RW +: RW] = RW'($urandom_range(0, 7));
      hz.rs2_e[k*RW +: RW] = RW'($urandom_range(0, 7));
      hz.rd_e[k*RW +: RW]  = RW'($urandom_range(0, 7));
      hz.rd_m[k*RW +: RW]  = RW'($urandom_range(0, 7));
      hz.rd_w[k*RW +: RW]  = RW'($urandom_range(0, 7));
    end
    hz.memread_e   = L'($urandom_range(0, 3));
    hz.regwrite_m  = L'($urandom_range(0, 3));
    hz.regwrite_w  = L'($urandom_range(0, 3));
    hz.redirect_e  = ($urandom_range(0, 9) == 0);
    hz.mdu_start_e = ($urandom_range(0, 5) == 0);
    hz.mdu_done    = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    // Hazard inputs held during reset must not produce stalls or flushes.
    hz.redirect_e = 1'b1; hz.mdu_start_e = 1'b1; #1;
    chk("rst_flush_d", 32'(hz.flush_d), 32'd0);
    chk("rst_stall_e", 32'(hz.stall_e), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 800; c++) begin
      rand_in();
      tick();
    end
    idle();
    repeat (12) tick();

    // Forwarding: M lane1 beats W lane0; then W lane0 alone.
    hz.rd_m = {5'd5, 5'd0}; hz.regwrite_m = 2'b10;
    hz.rd_w = {5'd0, 5'd5}; hz.regwrite_w = 2'b01;
    hz.rs1_e = {5'd0, 5'd5}; #1;
    chk("fwd_m_lane1", 32'(hz.fwd1_e[2:0]), 32'd2);
    hz.regwrite_m = 2'b00; #1;
    chk("fwd_w_lane0", 32'(hz.fwd1_e[2:0]), 32'd3);
    hz.rs1_e = '0; #1;
    chk("fwd_x0", 32'(hz.fwd1_e[2:0]), 32'd0);

    // Write-back masking.
    hz.rd_w = {5'd7, 5'd7}; hz.regwrite_w = 2'b11; #1;
    chk("we_same_rd", 32'(hz.we_w_mask), 32'd2);
    hz.rd_w = '0; #1;
    chk("we_x0", 32'(hz.we_w_mask), 32'd0);
    hz.rd_w = {5'd9, 5'd7}; #1;
    chk("we_distinct", 32'(hz.we_w_mask), 32'd3);
    idle();
    tick();

    // Load-use: one cycle of stall_f/stall_d/flush_e.
    hz.memread_e = 2'b01; hz.rd_e = {5'd0, 5'd3}; hz.rs2_d = {5'd3, 5'd0}; #1;
    chk("lu_stall_d", 32'(hz.stall_d), 32'd1);
    chk("lu_flush_e", 32'(hz.flush_e), 32'd1);
    chk("lu_stall_e", 32'(hz.stall_e), 32'd0);
    tick();
    idle(); #1;
    chk("lu_clear", 32'({hz.stall_f, hz.stall_d, hz.flush_e}), 32'd0);
    tick();

    // Redirect: three flush cycles.
    hz.redirect_e = 1'b1; #1;
    chk("flush_c0", 32'({hz.flush_d, hz.flush_e}), 32'd3);
    for (int c = 1; c <= 3; c++) begin
      tick(); hz.redirect_e = 1'b0; #1;
      chk("flush_run", 32'(hz.flush_d), (c < 3) ? 32'd1 : 32'd0);
    end
    tick();

    // Second redirect on cycle 2 extends the flush through cycle 4.
    for (int c = 0; c <= 5; c++) begin
      hz.redirect_e = (c == 0 || c == 2); #1;
      chk("flush_ext", 32'(hz.flush_e), (c <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    // MDU with done 5 cycles after accept.
    for (int c = 0; c <= 6; c++) begin
      hz.mdu_start_e = (c == 0); hz.mdu_done = (c == 5); #1;
      chk("mdu_stall", 32'(hz.stall_e), (c <= 4) ? 32'd1 : 32'd0);
      chk("mdu_stall_f", 32'(hz.stall_f), (c <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    // MDU timeout: pulse on cycle 7.
    for (int c = 0; c <= 8; c++) begin
      hz.mdu_start_e = (c == 0); #1;
      chk("mdu_tmo", 32'(hz.mdu_timeout), (c == 7) ? 32'd1 : 32'd0);
      chk("mdu_tmo_stall", 32'(hz.stall_d), (c <= 6) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    // Reset mid-wait drops stalls at once; RUN afterwards.
    hz.mdu_start_e = 1'b1; #1;
    tick();
    hz.mdu_start_e = 1'b0;
    tick();
    chk("pre_rst_stall", 32'(hz.stall_e), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_mid_stall", 32'({hz.stall_f, hz.stall_d, hz.stall_e}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_out", 32'({hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e,
                             hz.mdu_timeout}), 32'd0);
    hz.memread_e = 2'b10; hz.rd_e = {5'd4, 5'd0}; hz.rs1_d = {5'd0, 5'd4}; #1;
    chk("post_rst_lu", 32'(hz.stall_d), 32'd1);
    tick();
    idle();
    repeat (3) tick();

`ifdef HAZ_PERF_CNT_EN
    chk("lu_stall_cnt", hz.lu_stall_cnt, 32'(lu_n));
    chk("mdu_stall_cnt", hz.mdu_stall_cnt, 32'(mdu_n));
    chk("flush_cnt", hz.flush_cnt, 32'(fl_n));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_nway.md
Name: hazard_ctrl_nway

Overview:
Parametrised hazard controller for the N-issue in-order RISC-V pipeline; replaces the fixed dual-lane W-only forwarding unit.
- Forwarding from M and W stages for every issue lane, with age-ordered priority.
- Write-back write-enable masking when lanes collide on the same rd.
- Load-use stall detection.
- Sequential control FSM covering multicycle-unit (MDU) waits and multi-cycle branch flushes.
- Sits beside the decode/execute stage registers and drives their stall/flush controls.

Parameters:
LANES, 2, issue width; lane 0 is the oldest instruction in a bundle
REGW, 5, register index width
FLUSH_CYCLES, 1, cycles flush_d/flush_e are held after a redirect (1..7)
MDU_TIMEOUT, 64, maximum MDU wait cycles before the wait is forcibly ended
FWD_W, $clog2(2*LANES+1), forward-select width (derived; do not override)

Ports:
clk in 1 core clock
rst_n in 1 asynchronous active-low reset
rs1_d, rs2_d in LANES*REGW decode-stage source registers
rs1_e, rs2_e in LANES*REGW execute-stage source registers
rd_e in LANES*REGW execute-stage destinations
memread_e in LANES execute-stage lane is a load
rd_m, rd_w in LANES*REGW memory/write-back destinations
regwrite_m, regwrite_w in LANES write enables per lane in M/W
redirect_e in 1 taken branch or jump resolved in E (any lane)
mdu_start_e in 1 multicycle op accepted in E
mdu_done in 1 MDU result ready (one-cycle pulse)
fwd1_e, fwd2_e out LANES*FWD_W operand source select per lane
we_w_mask out LANES qualified register-file write enables
stall_f, stall_d, stall_e out 1 hold the PC / D register / E register
flush_d, flush_e out 1 bubble the D / E register
mdu_timeout out 1 one-cycle pulse when the MDU wait times out

Behaviour:
Reset (async assert, sync release): FSM=RUN, counters=0, mdu_timeout=0. All stall and flush outputs are 0 during reset. Combinational outputs follow their inputs.

Forward select encoding: 0 = register file; 1+k = M lane k; 1+LANES+k = W lane k.
- Forward only when source register != 0 and the producer's regwrite is set.
- Priority: the M stage beats the W stage; within a stage, the highest lane index (youngest) wins.
- Sources equal to x0 always select 0.

we_w_mask[k] = regwrite_w[k] AND no lane j>k has regwrite_w[j] with rd_w[j]==rd_w[k]. The youngest write wins. Writes to rd=0 are masked.

Load-use (lu) = any lane i with memread_e[i], rd_e[i]!=0, and rd_e[i] matching any lane's rs1_d/rs2_d. This check is combinational.

FSM states:
- RUN:
  - redirect_e -> flush_d=flush_e=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - else mdu_start_e -> stall_f=stall_d=stall_e=1, go to MDU_WAIT with cnt=0.
  - else lu -> stall_f=stall_d=1 and flush_e=1 for that cycle; stay in RUN.
- FLUSH: flush_d=flush_e=1 and cnt decrements; at cnt==1 go to RUN. A new redirect_e reloads cnt.
- MDU_WAIT: stall_f/d/e=1 and cnt increments.
  - mdu_done -> all stalls drop that same cycle; go to RUN.
  - cnt==MDU_TIMEOUT-1 without done -> pulse mdu_timeout, release the stalls, go to RUN.
  - redirect_e is ignored in this state, because E is frozen.

Simultaneous events:
- redirect_e beats mdu_start_e and lu; the flushed instruction's MDU start is discarded.
- mdu_done and mdu_start_e in the same cycle in MDU_WAIT: done is taken; start is ignored.

Counters use $clog2(max(FLUSH_CYCLES,MDU_TIMEOUT))+1 bits and saturate; there is no wrap.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds 32-bit outputs lu_stall_cnt, mdu_stall_cnt, flush_cnt. Each increments on every cycle its condition drives a stall/flush, saturates at 2^32-1, and resets to 0.
- Undefined: the ports and logic are absent; the rest of the block is unchanged.

Decomposition:
hazard_pkg holds:
- fsm enum haz_state_e {RUN, FLUSH, MDU_WAIT}
- FWD_REGFILE=0 constant
- function fwd_sel(lane, is_w) computing the encoding

One sub-module, hazard_fwd_lane: per-operand priority forward selector, instantiated 2*LANES times.

Test Plan:
- LANES=2; lane1 in M writes x5, lane0 in W writes x5; lane0 in E reads rs1=x5 -> fwd1_e lane0 = 2 (M lane1).
- W: lane0 and lane1 both write x7 -> we_w_mask=2'b10. Both write x0 -> we_w_mask=2'b00.
- Load in E lane0 rd=x3, D lane1 rs2=x3 -> one cycle of stall_f=stall_d=flush_e=1, then 0 on the next cycle.
- FLUSH_CYCLES=3, redirect_e pulse -> flush_d=flush_e high exactly 3 cycles. A second redirect on cycle 2 extends the flush to cycle 4.
- mdu_start_e, mdu_done 5 cycles later -> stalls high for cycles 0-4, low in the done cycle. With MDU_TIMEOUT=8 and no done -> mdu_timeout pulses on cycle 7.
- rst_n asserted mid-MDU_WAIT -> stalls drop immediately; after release the FSM is in RUN and all outputs are 0.
